// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch controller.
//   fetch_state_e : controller FSM states
//   INSTR_BYTES   : sequential PC increment in bytes
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2,
    ERROR = 2'd3
  } fetch_state_e;

  localparam int unsigned INSTR_BYTES = 4;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch controller bus bundle: instruction-memory request/response plus the
// downstream instruction valid/ready handshake.
//   master : the fetch controller (drives imem_req/imem_addr, instr_valid/instr)
//   slave  : memory + downstream consumer (drives imem_ack/imem_rdata, instr_ready)
interface fetch_ctrl_if #(
  parameter int unsigned WIDTH = 32
);

  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ack;
  logic [WIDTH-1:0] imem_rdata;
  logic             instr_valid;
  logic [WIDTH-1:0] instr;
  logic             instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr,
    output imem_ack, imem_rdata, instr_ready
  );

endinterface

// File: rtl/pc_target_calc.sv
// Next-PC target computation (combinational).
//   pc, imm, pc_src : current PC, branch offset, branch-taken select
//   target_c        : pc_src ? pc+imm : pc+INSTR_BYTES, modulo 2^WIDTH
//   misalign_c      : target is not word aligned
module pc_target_calc
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic             pc_src,
  output logic [WIDTH-1:0] target_c,
  output logic             misalign_c
);

  // Sum is truncated to WIDTH so carry out is discarded.
  always_comb begin
    target_c   = pc_src ? (pc + imm) : (pc + WIDTH'(INSTR_BYTES));
    misalign_c = |target_c[1:0];
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: requests the word at PC, holds it for the
// downstream consumer, then advances PC sequentially or by a branch offset.
//   clk, rst     : clock, asynchronous active-high reset
//   en           : run enable
//   PCsrc, ImmOp : branch taken / offset, used only on the accept cycle
//   bus          : imem request/response and instr valid/ready (master side)
//   PC           : address of the current or held instruction
//   instr_count  : number of accepted instructions (wrapping)
//   err          : sticky misaligned-target error
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h0000_0000)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] ImmOp,
  fetch_ctrl_if.master     bus,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] instr_count,
  output logic             err
);

  fetch_state_e     state;
  fetch_state_e     state_nxt;
  logic [WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0] instr_nxt;
  logic [WIDTH-1:0] count_nxt;
  logic             req_nxt;
  logic             valid_nxt;
  logic             err_nxt;
  logic [WIDTH-1:0] target;
  logic             misalign;

  pc_target_calc #(
    .WIDTH (WIDTH)
  ) u_target (
    .pc         (PC),
    .imm        (ImmOp),
    .pc_src     (PCsrc),
    .target_c   (target),
    .misalign_c (misalign)
  );

  assign bus.imem_addr = PC;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and next-datapath decode.
  always_comb begin
    state_nxt = state;
    pc_nxt    = PC;
    instr_nxt = bus.instr;
    count_nxt = instr_count;
    case (state)
      IDLE: begin
        if (en) state_nxt = FETCH;
      end
      FETCH: begin
        if (bus.imem_ack) begin
          instr_nxt = bus.imem_rdata;
          state_nxt = VALID;
        end
      end
      VALID: begin
        if (bus.instr_ready) begin
          count_nxt = instr_count + WIDTH'(1);
          if (misalign) begin
            state_nxt = ERROR;
          end else begin
            pc_nxt    = target;
            state_nxt = en ? FETCH : IDLE;
          end
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    // Handshake outputs are registered copies of the next state's decode.
    req_nxt   = (state_nxt == FETCH);
    valid_nxt = (state_nxt == VALID);
    err_nxt   = (state_nxt == ERROR);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      PC              <= RESET_PC;
      bus.instr       <= '0;
      instr_count     <= '0;
      bus.imem_req    <= 1'b0;
      bus.instr_valid <= 1'b0;
      err             <= 1'b0;
    end else begin
      PC              <= pc_nxt;
      bus.instr       <= instr_nxt;
      instr_count     <= count_nxt;
      bus.imem_req    <= req_nxt;
      bus.instr_valid <= valid_nxt;
      err             <= err_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: the stimulus thread pushes the expected
// {PC, instr} of every instruction it offers for acceptance; a monitor pops
// and compares on each accepted handshake. A second instance checks the
// RESET_PC wrap-around.
module tb_fetch_ctrl;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic        clk    = 1'b0;
  logic        rst    = 1'b0;
  logic        en     = 1'b0;
  logic        pc_src = 1'b0;
  logic [31:0] imm    = 32'h0;
  logic [31:0] pc;
  logic [31:0] cnt;
  logic        err;

  logic        rst2 = 1'b0;
  logic        en2  = 1'b0;
  logic [31:0] pc2;
  logic [31:0] cnt2;
  logic        err2;

  int          total = 0;
  int          bad   = 0;
  exp_t        sb[$];
  logic [31:0] m_pc  = 32'h0;

  fetch_ctrl_if #(.WIDTH(32)) bus  ();
  fetch_ctrl_if #(.WIDTH(32)) bus2 ();

  always #5 clk = ~clk;

  fetch_ctrl #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .PCsrc       (pc_src),
    .ImmOp       (imm),
    .bus         (bus),
    .PC          (pc),
    .instr_count (cnt),
    .err         (err)
  );

  fetch_ctrl #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk         (clk),
    .rst         (rst2),
    .en          (en2),
    .PCsrc       (1'b0),
    .ImmOp       (32'h0000_0003),
    .bus         (bus2),
    .PC          (pc2),
    .instr_count (cnt2),
    .err         (err2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare every accepted instruction against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.instr_valid && bus.instr_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: accept of %h with no expected entry", bus.instr);
      end else begin
        e = sb.pop_front();
        check("sb_instr", bus.instr, e.instr);
        check("sb_pc", pc, e.pc);
      end
    end
  end

  // One fetch + accept starting in FETCH. Branch inputs carry noise outside
  // the accept cycle; hold > 0 keeps ready low that many cycles in VALID.
  task automatic fetch_accept(input int ack_dly, input int hold, input logic [31:0] rdata,
                              input logic src, input logic [31:0] off,
                              input logic [31:0] exp_pc, input logic [31:0] exp_cnt,
                              input logic exp_req, input logic exp_err);
    int n = 0;
    while (!bus.imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", 32'(bus.imem_req), 32'd1);
    check("fetch_addr", bus.imem_addr, m_pc);
    pc_src = 1'b1;
    imm    = 32'h0000_0006;
    repeat (ack_dly) tick();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = rdata;
    check("valid_before_ack_edge", 32'(bus.instr_valid), 32'd0);
    tick();
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    check("valid_after_ack", 32'(bus.instr_valid), 32'd1);
    check("instr_capture", bus.instr, rdata);
    check("req_in_valid", 32'(bus.imem_req), 32'd0);
    for (int i = 0; i < hold; i++) begin
      bus.imem_ack = (i == 2);
      tick();
      bus.imem_ack = 1'b0;
      check("hold_instr", bus.instr, rdata);
      check("hold_pc", pc, m_pc);
      check("hold_req", 32'(bus.imem_req), 32'd0);
      check("hold_valid", 32'(bus.instr_valid), 32'd1);
    end
    sb.push_back('{pc: m_pc, instr: rdata});
    bus.instr_ready = 1'b1;
    pc_src = src;
    imm    = off;
    tick();
    bus.instr_ready = 1'b0;
    pc_src = 1'b1;
    imm    = 32'h0000_0002;
    check("acc_pc", pc, exp_pc);
    check("acc_count", cnt, exp_cnt);
    check("acc_req", 32'(bus.imem_req), 32'(exp_req));
    check("acc_err", 32'(err), 32'(exp_err));
    check("acc_valid", 32'(bus.instr_valid), 32'd0);
    m_pc = exp_pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.imem_ack     = 1'b0;
    bus.imem_rdata   = 32'h0;
    bus.instr_ready  = 1'b0;
    bus2.imem_ack    = 1'b0;
    bus2.imem_rdata  = 32'h0;
    bus2.instr_ready = 1'b0;

    #1 rst = 1'b1; rst2 = 1'b1;
    #2;
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_pc", pc, 32'h0);
    check("rst_instr", bus.instr, 32'h0);
    check("rst_count", cnt, 32'h0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_pc_wrap", pc2, 32'hFFFF_FFFC);
    tick();
    tick();
    rst = 1'b0;

    // Stays idle without en; ack in IDLE is ignored.
    tick();
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_0001;
    tick();
    bus.imem_ack   = 1'b0;
    check("idle_req", 32'(bus.imem_req), 32'd0);
    check("idle_valid", 32'(bus.instr_valid), 32'd0);
    check("idle_ack_ignored", bus.instr, 32'h0);

    // Basic fetch, sequential stepping to 0x10, then branches.
    en = 1'b1;
    tick();
    check("first_req", 32'(bus.imem_req), 32'd1);
    m_pc = 32'h0;
    fetch_accept(2, 0, 32'h0050_0093, 1'b0, 32'h0, 32'h4, 32'd1, 1'b1, 1'b0);
    fetch_accept(0, 0, 32'h0000_0013, 1'b0, 32'h0, 32'h8, 32'd2, 1'b1, 1'b0);
    fetch_accept(1, 0, 32'h0000_0113, 1'b0, 32'h0, 32'hC, 32'd3, 1'b1, 1'b0);
    fetch_accept(0, 0, 32'h0000_0213, 1'b0, 32'h0, 32'h10, 32'd4, 1'b1, 1'b0);
    fetch_accept(0, 0, 32'h0000_0313, 1'b1, 32'hFFFF_FFF0, 32'h0, 32'd5, 1'b1, 1'b0);
    fetch_accept(0, 0, 32'h0000_0413, 1'b1, 32'h0000_0010, 32'h10, 32'd6, 1'b1, 1'b0);
    fetch_accept(0, 0, 32'h0000_0513, 1'b1, 32'h0000_0008, 32'h18, 32'd7, 1'b1, 1'b0);

    // Back-pressure in VALID, then en dropped mid-fetch.
    fetch_accept(1, 5, 32'h0000_0613, 1'b0, 32'h0, 32'h1C, 32'd8, 1'b1, 1'b0);
    en = 1'b0;
    fetch_accept(1, 0, 32'h0000_0713, 1'b0, 32'h0, 32'h20, 32'd9, 1'b0, 1'b0);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_0002;
    tick();
    bus.imem_ack   = 1'b0;
    tick();
    check("en_off_req", 32'(bus.imem_req), 32'd0);
    check("en_off_valid", 32'(bus.instr_valid), 32'd0);
    check("en_off_instr", bus.instr, 32'h0000_0713);

    // Asynchronous reset between edges while requesting, with ack in flight.
    en = 1'b1;
    tick();
    check("pre_rst_req", 32'(bus.imem_req), 32'd1);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_0042;
    #2 rst = 1'b1;
    #1;
    check("arst_req", 32'(bus.imem_req), 32'd0);
    check("arst_valid", 32'(bus.instr_valid), 32'd0);
    check("arst_pc", pc, 32'h0);
    check("arst_instr", bus.instr, 32'h0);
    check("arst_count", cnt, 32'h0);
    check("arst_err", 32'(err), 32'd0);
    en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    bus.imem_ack = 1'b0;
    check("post_rst_valid", 32'(bus.instr_valid), 32'd0);
    check("post_rst_instr", bus.instr, 32'h0);
    check("post_rst_req", 32'(bus.imem_req), 32'd0);

    // Misaligned branch target -> sticky ERROR.
    en = 1'b1;
    tick();
    m_pc = 32'h0;
    fetch_accept(0, 0, 32'h0010_0093, 1'b0, 32'h0, 32'h4, 32'd1, 1'b1, 1'b0);
    fetch_accept(0, 0, 32'h0020_0093, 1'b0, 32'h0, 32'h8, 32'd2, 1'b1, 1'b0);
    fetch_accept(0, 0, 32'h0030_0093, 1'b1, 32'h0000_0002, 32'h8, 32'd3, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      bus.imem_ack    = 1'b1;
      bus.imem_rdata  = 32'hBAD0_0003;
      bus.instr_ready = 1'b1;
      tick();
      check("err_sticky", 32'(err), 32'd1);
      check("err_req", 32'(bus.imem_req), 32'd0);
      check("err_valid", 32'(bus.instr_valid), 32'd0);
      check("err_pc", pc, 32'h8);
      check("err_count", cnt, 32'd3);
      check("err_instr", bus.instr, 32'h0030_0093);
    end
    bus.imem_ack    = 1'b0;
    bus.instr_ready = 1'b0;
    en              = 1'b0;
    rst = 1'b1;
    #1;
    check("err_cleared", 32'(err), 32'd0);
    tick();
    rst = 1'b0;

    // Wrap from RESET_PC = 0xFFFF_FFFC.
    rst2 = 1'b0;
    en2  = 1'b1;
    tick();
    check("wrap_req", 32'(bus2.imem_req), 32'd1);
    check("wrap_addr", bus2.imem_addr, 32'hFFFF_FFFC);
    bus2.imem_ack   = 1'b1;
    bus2.imem_rdata = 32'h0000_0013;
    tick();
    bus2.imem_ack = 1'b0;
    check("wrap_valid", 32'(bus2.instr_valid), 32'd1);
    check("wrap_instr", bus2.instr, 32'h0000_0013);
    bus2.instr_ready = 1'b1;
    en2 = 1'b0;
    tick();
    bus2.instr_ready = 1'b0;
    check("wrap_pc", pc2, 32'h0);
    check("wrap_count", cnt2, 32'd1);
    check("wrap_err", 32'(err2), 32'd0);
    check("wrap_idle_req", 32'(bus2.imem_req), 32'd0);

    tick();
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the width of the address, data, immediate and counter.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, SHALL set the PC value loaded on reset.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 en  input  1  run enable; fetching starts and continues only while it is high.
REQ-006 PCsrc  input  1  branch taken; sampled only on the instruction-accept cycle.
REQ-007 ImmOp  input  WIDTH  branch offset; sampled with PCsrc.
REQ-008 imem_req  output  1  instruction-memory request.
REQ-009 imem_addr  output  WIDTH  request address; equals PC.
REQ-010 imem_ack  input  1  memory response valid.
REQ-011 imem_rdata  input  WIDTH  instruction word; valid when imem_ack=1.
REQ-012 instr_valid  output  1  instr holds an unconsumed instruction.
REQ-013 instr  output  WIDTH  registered instruction.
REQ-014 instr_ready  input  1  downstream accepts instr.
REQ-015 PC  output  WIDTH  address of the current or held instruction.
REQ-016 instr_count  output  WIDTH  count of accepted instructions.
REQ-017 err  output  1  sticky misaligned-target error.

Function
REQ-018 The FSM SHALL have four states: IDLE, FETCH, VALID and ERROR (held in a shared package enum).
REQ-019 IDLE: outputs imem_req=0 and instr_valid=0; the FSM SHALL go to FETCH on the first edge with en=1.
REQ-020 FETCH: imem_req=1 and imem_addr=PC, held until imem_ack=1; there is no combinational ack-to-req path.
REQ-021 In FETCH with imem_ack=1: instr<=imem_rdata, and the FSM SHALL go to VALID on the same edge; minimum latency from req to instr_valid is 1 cycle after ack.
REQ-022 imem_ack outside FETCH SHALL be ignored, with no state or instr change.
REQ-023 VALID: instr_valid=1 and imem_req=0; instr and PC SHALL be held stable until instr_ready=1.
REQ-024 The accept cycle is VALID with instr_ready=1; on it the target SHALL be PCsrc ? PC+ImmOp : PC+4.
REQ-025 All target arithmetic SHALL be modulo 2^WIDTH, with carry discarded, so 32'hFFFF_FFFC+4 yields 0.
REQ-026 On accept with target[1:0]==0: PC<=target, instr_count<=instr_count+1 (wrapping), and next state is FETCH if en=1, else IDLE.
REQ-027 On accept with target[1:0]!=0: PC is unchanged, instr_count<=instr_count+1, and next state is ERROR.
REQ-028 ERROR: err=1, imem_req=0 and instr_valid=0; the FSM SHALL stay in ERROR until rst.
REQ-029 en deasserted during FETCH or VALID SHALL NOT abort the transfer; the block SHALL finish the outstanding fetch and accept, then go to IDLE.
REQ-030 Ack and accept cannot occur in the same cycle because they belong to different states; no bypass is permitted.
REQ-031 PCsrc and ImmOp outside the accept cycle SHALL have no effect.

Reset
REQ-032 rst=1 SHALL immediately, without waiting for clk, force state=IDLE, PC=RESET_PC, instr=0, instr_count=0, err=0, imem_req=0 and instr_valid=0.
REQ-033 Reset asserted mid-FETCH SHALL drop imem_req asynchronously, and an in-flight ack SHALL be discarded.
REQ-034 After rst deasserts, the FSM SHALL remain in IDLE until en=1 is sampled.

Structure
REQ-035 Package fetch_pkg SHALL hold the state enum (IDLE, FETCH, VALID, ERROR) and the localparam INSTR_BYTES=4.
REQ-036 One combinational sub-module, pc_target_calc, SHALL compute the target and misalign flag from PC, ImmOp and PCsrc; the FSM and registers SHALL stay in fetch_ctrl.

Verification
REQ-037 Reset then en=1, with ack 2 cycles after req and rdata=32'h0050_0093: instr_valid rises 1 cycle after ack, instr=32'h0050_0093, PC=0; ready=1, PCsrc=0 -> PC=4, instr_count=1, imem_req=1.
REQ-038 PC=32'h10, PCsrc=1, ImmOp=32'hFFFF_FFF0, accepted: PC=0. Repeat with ImmOp=8: PC=32'h18.
REQ-039 RESET_PC=32'hFFFF_FFFC with sequential accept: PC wraps to 0; ERROR is not entered.
REQ-040 PC=8, PCsrc=1, ImmOp=2: err=1 and state stays ERROR; later acks and readys are ignored until rst.
REQ-041 instr_ready held low 5 cycles in VALID: instr and PC stay stable and imem_req=0; en dropped in FETCH -> fetch completes, then IDLE after accept.
REQ-042 rst pulsed between clk edges while imem_req=1: imem_req=0 before the next edge, all outputs at reset values, and a following ack is ignored.
